lfsr_capture_display: RTL and testbench
=======================================

Name: lfsr_capture_display

Overview:
- Parametrised successor of the LFSR-to-display experiment top.
- Generates pseudo-random data with a maximal-length LFSR of selectable width.
- Captures that data into a register under one of four run modes, counts the captures, and time-multiplexes the captured value onto an N-digit active-low seven-segment display.
- Used as the lab board top and as a stimulus source for later experiments.

Parameters:
- NUM_DIGITS, 4: display digits; legal 2..8; DATA_WIDTH = 4*NUM_DIGITS.
- DATA_DELAY_IN_CYCLES, 2: clk cycles per LFSR tick; legal >= 1.
- DISPLAY_DELAY_IN_CYCLES, 1: clk cycles each digit is driven; legal >= 1.
- LFSR_SEED, 1: reset value of the LFSR, truncated to DATA_WIDTH; must be nonzero.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  capture strobe, used in mode 00 only.
- i_mode  in  2  00 RUN_WE, 01 FREE, 10 STEP, 11 HOLD.
- i_step  in  1  step request, used in STEP mode only; rising-edge detected.
- o_data  out  DATA_WIDTH  captured register value.
- o_valid  out  1  high once the register has loaded at least once since reset.
- o_capture_count  out  8  number of register loads, saturating.
- o_seven_segments  out  8  {dp,g,f,e,d,c,b,a}, active-low; dp always 1.
- o_anode_pins  out  NUM_DIGITS  one-hot active-low digit select.

Behaviour:
- Reset, sampled at the clk edge when rst=1:
  - LFSR = LFSR_SEED; o_data = 0; o_valid = 0; o_capture_count = 0.
  - Tick counter = 0; step_prev = 0; scan counter = 0; digit index = 0.
  - o_anode_pins all 1; o_seven_segments = 8'hFF.
  - Reset mid-operation aborts everything; no partial state survives.
- Tick generator:
  - Counter runs 0..DATA_DELAY_IN_CYCLES-1 and wraps.
  - tick=1 for one cycle when the counter equals DATA_DELAY_IN_CYCLES-1.
  - First tick is in cycle DATA_DELAY_IN_CYCLES after reset release. DELAY=1 gives a tick every cycle.
  - The counter free-runs in all modes and is not cleared by mode changes.
- LFSR (Fibonacci, shift left):
  - next = {lfsr[W-2:0], fb}, fb = XOR of the tap bits (1-based taps).
  - Taps by width: 8: 8,6,5,4; 12: 12,6,4,1; 16: 16,15,13,4; 20: 20,17; 24: 24,23,22,17; 28: 28,25; 32: 32,22,2,1.
  - The all-zero state is unreachable from a nonzero seed.
- Advance condition:
  - RUN_WE and FREE: advance on tick.
  - STEP: advance on step_rise = i_step & ~step_prev. step_prev is registered every cycle in all modes.
  - HOLD: never advance.
- Register load (load => o_data, o_valid = 1, count++ saturating at 255):
  - RUN_WE: load when we=1. Loads the LFSR value present before that edge. we together with tick loads the pre-advance value.
  - FREE: load on every tick, with the pre-advance value. o_data therefore lags the LFSR by one step.
  - STEP: load on step_rise, with the pre-advance value.
  - HOLD: no load; we ignored.
- Mode changes take effect at the edge where the new i_mode is sampled. No glitch states.
- Display scan:
  - Scan counter runs 0..DISPLAY_DELAY_IN_CYCLES-1.
  - At wrap, the digit index goes to (index+1) mod NUM_DIGITS.
  - Digit k shows nibble o_data[4k+3:4k]; digit 0 is the least-significant nibble.
- Display outputs are registered, one cycle behind the index and o_data:
  - o_anode_pins = ~(1 << index).
  - Segments use the hex encoding 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- Width rule: o_capture_count does not wrap. At 255 it stays 255.

Test Plan:
1. Reset hold, then release with NUM_DIGITS=4 -> during reset anodes 1111, segments FF, o_data 0, count 0, o_valid 0; one cycle after release anodes 1110, segments C0.
2. Reset, then mode FREE with DATA_DELAY=2, seed 1, width 16 -> o_data steps 0x0001, 0x0002, 0x0004, 0x0008, 0x0011, each value held 2 cycles; count increments per tick.
3. Mode RUN_WE with we pulsed on a tick cycle while the LFSR holds 0x0008 -> o_data = 0x0008 (not 0x0011); count +1; o_valid = 1. we=0 for 20 cycles -> o_data unchanged.
4. Mode STEP with i_step held high 5 cycles, then low, then one 1-cycle pulse -> exactly two loads and two LFSR advances; tick ignored.
5. Capture 0x0011, switch to HOLD, DISPLAY_DELAY=1 -> repeating anode/segment pairs 1110/F9, 1101/F9, 1011/C0, 0111/C0; o_data and the LFSR frozen.
6. FREE with DELAY=1 for 300 cycles -> count saturates at 255. Assert rst for one cycle mid-scan -> all state returns to reset values at that edge.

Source files
------------

// File: rtl/lfsr_capture_display.sv
// rtl/lfsr_capture_display.sv - LFSR data source with mode-controlled capture register,
// saturating capture counter and multiplexed active-low seven-segment display.
module lfsr_capture_display #(
  parameter int          NUM_DIGITS              = 4,
  parameter int          DATA_DELAY_IN_CYCLES    = 2,
  parameter int          DISPLAY_DELAY_IN_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED               = 32'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [1:0]                i_mode,
  input  logic                      i_step,
  output logic [4*NUM_DIGITS-1:0]   o_data,
  output logic                      o_valid,
  output logic [7:0]                o_capture_count,
  output logic [7:0]                o_seven_segments,
  output logic [NUM_DIGITS-1:0]     o_anode_pins
);

  localparam int DATA_WIDTH = 4 * NUM_DIGITS;
  localparam int TW = (DATA_DELAY_IN_CYCLES > 1) ? $clog2(DATA_DELAY_IN_CYCLES) : 1;
  localparam int SW = (DISPLAY_DELAY_IN_CYCLES > 1) ? $clog2(DISPLAY_DELAY_IN_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [1:0] MODE_RUN_WE = 2'b00;
  localparam logic [1:0] MODE_FREE   = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // Tap bit masks (bit t-1 set for 1-based tap t) of the maximal-length polynomials.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      8:       tap_mask = 32'h0000_00B8;
      12:      tap_mask = 32'h0000_0829;
      16:      tap_mask = 32'h0000_D008;
      20:      tap_mask = 32'h0009_0000;
      24:      tap_mask = 32'h00E1_0000;
      28:      tap_mask = 32'h0900_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] v);
    case (v)
      4'h0:    seg_encode = 8'hC0;
      4'h1:    seg_encode = 8'hF9;
      4'h2:    seg_encode = 8'hA4;
      4'h3:    seg_encode = 8'hB0;
      4'h4:    seg_encode = 8'h99;
      4'h5:    seg_encode = 8'h92;
      4'h6:    seg_encode = 8'h82;
      4'h7:    seg_encode = 8'hF8;
      4'h8:    seg_encode = 8'h80;
      4'h9:    seg_encode = 8'h90;
      4'hA:    seg_encode = 8'h88;
      4'hB:    seg_encode = 8'h83;
      4'hC:    seg_encode = 8'hC6;
      4'hD:    seg_encode = 8'hA1;
      4'hE:    seg_encode = 8'h86;
      default: seg_encode = 8'h8E;
    endcase
  endfunction

  localparam logic [31:0]           TAPS_32   = tap_mask(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] TAP_BITS  = TAPS_32[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SEED      = LFSR_SEED[DATA_WIDTH-1:0];
  localparam logic [TW-1:0]         TICK_LAST = TW'(DATA_DELAY_IN_CYCLES - 1);
  localparam logic [SW-1:0]         SCAN_LAST = SW'(DISPLAY_DELAY_IN_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [DATA_WIDTH-1:0] lfsr;
  logic [DATA_WIDTH-1:0] lfsr_next;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic                  step_prev;
  logic                  step_rise;
  logic                  advance;
  logic                  load;
  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            nibble;

  assign tick      = (tick_cnt == TICK_LAST);
  assign step_rise = i_step & ~step_prev;
  assign lfsr_next = {lfsr[DATA_WIDTH-2:0], ^(lfsr & TAP_BITS)};

  always_comb begin
    advance = 1'b0;
    load    = 1'b0;
    case (i_mode)
      MODE_RUN_WE: begin
        advance = tick;
        load    = we;
      end
      MODE_FREE: begin
        advance = tick;
        load    = tick;
      end
      MODE_STEP: begin
        advance = step_rise;
        load    = step_rise;
      end
      MODE_HOLD: begin
        advance = 1'b0;
        load    = 1'b0;
      end
      default: begin
        advance = 1'b0;
        load    = 1'b0;
      end
    endcase
  end

  // Loads always take the LFSR value present before the edge, even when it advances too.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr            <= SEED;
      tick_cnt        <= '0;
      step_prev       <= 1'b0;
      o_data          <= '0;
      o_valid         <= 1'b0;
      o_capture_count <= 8'd0;
    end else begin
      step_prev <= i_step;
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      if (advance) begin
        lfsr <= lfsr_next;
      end
      if (load) begin
        o_data  <= lfsr;
        o_valid <= 1'b1;
        if (o_capture_count != 8'hFF) begin
          o_capture_count <= o_capture_count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nibble = o_data[4*k +: 4];
      end
    end
  end

  // Display outputs are registered, so they trail idx and o_data by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt         <= '0;
      idx              <= '0;
      o_anode_pins     <= '1;
      o_seven_segments <= 8'hFF;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      o_anode_pins     <= ~(NUM_DIGITS'(1) << idx);
      o_seven_segments <= seg_encode(nibble);
    end
  end

endmodule

// File: tb/tb_lfsr_capture_display.sv
// tb/tb_lfsr_capture_display.sv - directed self-checking bench for lfsr_capture_display.
module tb_lfsr_capture_display;

  logic        clk = 1'b0;
  logic        rst, we, i_step;
  logic [1:0]  i_mode;
  logic [15:0] o_data;
  logic        o_valid;
  logic [7:0]  o_capture_count, o_seven_segments;
  logic [3:0]  o_anode_pins;

  logic        rst_f;
  logic [1:0]  mode_f;
  logic        we_f = 1'b0;
  logic        step_f = 1'b0;
  logic [15:0] data_f;
  logic        valid_f;
  logic [7:0]  count_f, seg_f;
  logic [3:0]  an_f;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] RUN_WE = 2'b00, FREE = 2'b01, STEP = 2'b10, HOLD = 2'b11;

  always #5 clk = ~clk;

  lfsr_capture_display #(
    .NUM_DIGITS(4), .DATA_DELAY_IN_CYCLES(2), .DISPLAY_DELAY_IN_CYCLES(1), .LFSR_SEED(32'd1)
  ) u_dut (
    .clk(clk), .rst(rst), .we(we), .i_mode(i_mode), .i_step(i_step),
    .o_data(o_data), .o_valid(o_valid), .o_capture_count(o_capture_count),
    .o_seven_segments(o_seven_segments), .o_anode_pins(o_anode_pins)
  );

  lfsr_capture_display #(
    .NUM_DIGITS(4), .DATA_DELAY_IN_CYCLES(1), .DISPLAY_DELAY_IN_CYCLES(1), .LFSR_SEED(32'd1)
  ) u_fast (
    .clk(clk), .rst(rst_f), .we(we_f), .i_mode(mode_f), .i_step(step_f),
    .o_data(data_f), .o_valid(valid_f), .o_capture_count(count_f),
    .o_seven_segments(seg_f), .o_anode_pins(an_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] free_seq [6];
    logic [3:0]  an_exp;
    int          d;
    free_seq = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};

    rst = 1'b1; we = 1'b0; i_step = 1'b0; i_mode = RUN_WE;
    rst_f = 1'b1; mode_f = HOLD;
    cyc(3);
    check("rst_anodes", o_anode_pins, 4'hF);
    check("rst_segments", o_seven_segments, 8'hFF);
    check("rst_data", o_data, 16'h0);
    check("rst_count", o_capture_count, 8'd0);
    check("rst_valid", o_valid, 1'b0);

    // Release in RUN_WE: first display cycle, then capture 0x0008 on a tick edge.
    rst = 1'b0;
    cyc(1);
    check("release_anodes", o_anode_pins, 4'hE);
    check("release_segments", o_seven_segments, 8'hC0);
    check("release_valid", o_valid, 1'b0);
    cyc(6);
    we = 1'b1;
    cyc(1);
    we = 1'b0;
    check("we_tick_data", o_data, 16'h0008);
    check("we_tick_count", o_capture_count, 8'd1);
    check("we_tick_valid", o_valid, 1'b1);
    cyc(20);
    check("we_idle_data", o_data, 16'h0008);
    check("we_idle_count", o_capture_count, 8'd1);

    // FREE with delay 2: each value held two cycles, lagging the LFSR by one step.
    rst = 1'b1; i_mode = FREE;
    cyc(2);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check($sformatf("free_data_e%0d", k), o_data, free_seq[k/2]);
      check($sformatf("free_count_e%0d", k), o_capture_count, 32'(k/2));
    end

    // HOLD on 0x0011: display scan pattern, data and LFSR frozen.
    i_mode = HOLD;
    for (int k = 11; k <= 18; k++) begin
      cyc(1);
      d = (k - 1) % 4;
      an_exp = ~(4'b0001 << d);
      check($sformatf("hold_anodes_e%0d", k), o_anode_pins, an_exp);
      check($sformatf("hold_segments_e%0d", k), o_seven_segments, (d < 2) ? 8'hF9 : 8'hC0);
    end
    check("hold_data", o_data, 16'h0011);
    check("hold_count", o_capture_count, 8'd5);
    i_mode = RUN_WE; we = 1'b1;
    cyc(1);
    we = 1'b0;
    check("hold_lfsr_frozen", o_data, 16'h0022);
    check("hold_after_count", o_capture_count, 8'd6);

    // STEP: held-high step gives one load, a later pulse gives one more.
    rst = 1'b1; i_mode = STEP;
    cyc(2);
    rst = 1'b0; i_step = 1'b1;
    cyc(5);
    i_step = 1'b0;
    check("step_hold_data", o_data, 16'h0001);
    check("step_hold_count", o_capture_count, 8'd1);
    cyc(7);
    check("step_idle_data", o_data, 16'h0001);
    check("step_idle_count", o_capture_count, 8'd1);
    i_step = 1'b1;
    cyc(1);
    i_step = 1'b0;
    check("step_pulse_data", o_data, 16'h0002);
    check("step_pulse_count", o_capture_count, 8'd2);
    cyc(6);
    i_mode = RUN_WE; we = 1'b1;
    cyc(1);
    we = 1'b0;
    check("step_two_advances", o_data, 16'h0004);
    check("step_final_count", o_capture_count, 8'd3);

    // FREE with delay 1: tick every cycle, count saturates, reset mid-scan.
    rst_f = 1'b0; mode_f = FREE;
    cyc(1);
    check("fast_data_e1", data_f, 16'h0001);
    cyc(1);
    check("fast_data_e2", data_f, 16'h0002);
    cyc(1);
    check("fast_data_e3", data_f, 16'h0004);
    check("fast_count_e3", count_f, 8'd3);
    cyc(251);
    check("fast_count_254", count_f, 8'd254);
    cyc(1);
    check("fast_count_255", count_f, 8'd255);
    cyc(45);
    check("fast_count_sat", count_f, 8'd255);
    rst_f = 1'b1;
    cyc(1);
    check("midrst_data", data_f, 16'h0);
    check("midrst_count", count_f, 8'd0);
    check("midrst_valid", valid_f, 1'b0);
    check("midrst_anodes", an_f, 4'hF);
    check("midrst_segments", seg_f, 8'hFF);
    rst_f = 1'b0;
    cyc(1);
    check("midrst_reseed", data_f, 16'h0001);
    check("midrst_rel_anodes", an_f, 4'hE);
    check("midrst_rel_segments", seg_f, 8'hC0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
